seg_timer_multi: RTL and testbench

- Parametrised multiplexed 7-segment up/down timer. Successor to the fixed mm:ss display clock.
- Generalised to 4 digits (mm:ss) or 6 digits (hh:mm:ss), with a configurable display polarity.
- Adds run/pause/clear control, BCD preset load, a countdown mode with an expiry flag, and optional leading-zero blanking.
- Sits in the user project area and drives the digit-enable and segment I/O pads directly from the system clock.

---
 rtl/seg_timer_pkg.sv | 32 +++
 rtl/seg_timer_multi_digit.sv | 25 ++
 rtl/seg_timer_multi.sv | 95 +++++++++
 tb/tb_seg_timer_multi.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg_timer_pkg.sv
// seg_timer_pkg: segment patterns, per-digit moduli and load clamping for seg_timer_multi
package seg_timer_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [3:0] MAX_ONES = 4'd9;
  localparam logic [3:0] MAX_TENS_MS = 4'd5;
  localparam logic [3:0] MAX_TENS_H = 4'd9;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return SEG_BLANK;
    endcase
  endfunction
  // Even positions are ones digits; position 5 is the hours tens digit.
  function automatic int digit_mod(input int i);
    return (i % 2 == 0 || i == 5) ? 10 : 6;
  endfunction
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input int i);
    logic [3:0] lim;
    lim = (i % 2 == 0) ? MAX_ONES : (i == 5) ? MAX_TENS_H : MAX_TENS_MS;
    return d > lim ? lim : d;
  endfunction
endpackage

// File: rtl/seg_timer_multi_digit.sv
// bcd_mod_digit: one modulo-MOD BCD digit with load, up/down step and wrap detection
module bcd_mod_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_down,
  input  logic       i_load,
  input  logic [3:0] i_load_d,
  output logic [3:0] o_q,
  output logic       o_wrap,
  output logic       o_is_zero
);
  localparam logic [3:0] MAX = 4'(MOD - 1);
  logic [3:0] r_q;
  assign o_q = r_q;
  assign o_is_zero = r_q == 4'd0;
  // Wrap is ungated by i_en so the top can form all carries without a feedback loop.
  assign o_wrap = i_down ? o_is_zero : r_q == MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (i_load) r_q <= i_load_d;
    else if (i_en) r_q <= i_down ? (o_is_zero ? MAX : r_q - 4'd1) : (o_wrap ? 4'd0 : r_q + 4'd1);
endmodule

// File: rtl/seg_timer_multi.sv
// seg_timer_multi: multiplexed 7-segment up/down timer with run control, preset load and expiry
module seg_timer_multi
  import seg_timer_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int CC = 1,
  parameter int FREQ = 2000,
  parameter int SCAN_PER_SEC = 25,
  parameter int BLANK_LZ = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               mode_down,
  input  logic               load_en,
  input  logic [4*N_DIG-1:0] load_val,
  output logic [6:0]         seven_seg,
  output logic [N_DIG-1:0]   digit_en,
  output logic               running,
  output logic               expired
);
  localparam int DD_RAW = FREQ / (N_DIG * SCAN_PER_SEC);
  localparam int DIG_DUR = DD_RAW < 1 ? 1 : DD_RAW;
  localparam int CW = DIG_DUR > 1 ? $clog2(DIG_DUR) : 1;
  localparam int PW = $clog2(FREQ);
  localparam int IW = $clog2(N_DIG);
  logic [4*N_DIG-1:0] w_qv, w_ld;
  logic [N_DIG-1:0] w_zero, w_lim, w_cy, w_lz, w_den;
  logic w_tick, w_load, w_go, w_all_zero, w_at_one, w_expire, w_blank, w_scan_tc, w_unused;
  logic [6:0] w_seg;
  logic r_run, r_exp;
  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_scan;
  logic [IW-1:0] r_idx;
  logic [6:0] r_seg;
  logic [N_DIG-1:0] r_den;
  assign w_tick = r_run && r_pre == PW'(FREQ - 1);
  assign w_load = clear | load_en;
  assign w_go = start & ~stop;
  assign w_all_zero = &w_zero;
  assign w_at_one = w_qv[3:0] == 4'd1 && &w_zero[N_DIG-1:1];
  assign w_expire = w_tick & mode_down & w_at_one & ~w_load;
  assign w_unused = w_lim[N_DIG-1];
  genvar i;
  generate
    for (i = 0; i < N_DIG; i++) begin : g_dig
      if (i == 0) begin : g_c0
        assign w_cy[i] = w_tick;
      end else begin : g_cn
        assign w_cy[i] = w_tick & (&w_lim[i-1:0]);
      end
      assign w_ld[4*i+:4] = clear ? 4'd0 : clamp_digit(load_val[4*i+:4], i);
      assign w_lz[i] = &w_zero[N_DIG-1:i];
      bcd_mod_digit #(.MOD(digit_mod(i))) u_dig (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_cy[i]),
        .i_down   (mode_down),
        .i_load   (w_load),
        .i_load_d (w_ld[4*i+:4]),
        .o_q      (w_qv[4*i+:4]),
        .o_wrap   (w_lim[i]),
        .o_is_zero(w_zero[i])
      );
    end
  endgenerate
  assign w_scan_tc = r_scan == CW'(DIG_DUR - 1);
  assign w_blank = BLANK_LZ != 0 && r_idx != '0 && w_lz[r_idx];
  assign w_seg = w_blank ? SEG_BLANK : seg_decode(w_qv[4*r_idx+:4]);
  assign w_den = N_DIG'(1) << r_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_run <= 1'b0;
      r_exp <= 1'b0;
      r_pre <= '0;
      r_scan <= '0;
      r_idx <= '0;
      r_seg <= CC != 0 ? SEG_0 : ~SEG_0;
      r_den <= CC != 0 ? ~N_DIG'(1) : N_DIG'(1);
    end else begin
      r_run <= (w_load | stop | w_expire) ? 1'b0 : w_go ? ~(mode_down & w_all_zero) : r_run;
      r_exp <= w_load ? 1'b0 : (w_expire | (w_go & mode_down & w_all_zero)) ? 1'b1 : w_go ? 1'b0 : r_exp;
      r_pre <= w_load ? '0 : w_tick ? '0 : r_run ? r_pre + 1'b1 : r_pre;
      r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
      r_idx <= w_scan_tc ? (r_idx == IW'(N_DIG - 1) ? '0 : r_idx + 1'b1) : r_idx;
      r_seg <= CC != 0 ? w_seg : ~w_seg;
      r_den <= CC != 0 ? ~w_den : w_den;
    end
  assign seven_seg = r_seg;
  assign digit_en = r_den;
  assign running = r_run;
  assign expired = r_exp;
endmodule

// File: tb/tb_seg_timer_multi.sv
// tb_seg_timer_multi: directed checks of a 4-digit CC timer and a 6-digit CA blanking timer
module tb_seg_timer_multi;
  logic clk = 0, rst = 0;
  logic start = 0, stop = 0, clear = 0, mode_down = 0, load_en = 0;
  logic [15:0] load_val = '0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] den_a;
  logic [5:0] den_b;
  logic run_a, exp_a, run_b, exp_b;
  logic tie0 = 0, ld_b = 0;
  logic [23:0] lv_b = '0;
  logic [41:0] cap;
  logic [6:0] seg_lut [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  logic [3:0] scan_exp [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
  int checks = 0, errors = 0;

  seg_timer_multi #(.N_DIG(4), .CC(1), .FREQ(8), .SCAN_PER_SEC(1), .BLANK_LZ(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .mode_down(mode_down),
    .load_en(load_en), .load_val(load_val), .seven_seg(seg_a), .digit_en(den_a),
    .running(run_a), .expired(exp_a));

  seg_timer_multi #(.N_DIG(6), .CC(0), .FREQ(8), .SCAN_PER_SEC(1), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst(rst), .start(tie0), .stop(tie0), .clear(tie0), .mode_down(tie0),
    .load_en(ld_b), .load_val(lv_b), .seven_seg(seg_b), .digit_en(den_b),
    .running(run_b), .expired(exp_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records the segments shown while each digit is the single active one.
  task automatic capture(input bit sel, input int n, output logic [41:0] segs);
    segs = 'x;
    for (int k = 0; k < n; k++) begin
      step();
      if (!sel) begin
        for (int d = 0; d < 4; d++)
          if ($countones(~den_a) == 1 && !den_a[d]) segs[7*d+:7] = seg_a;
      end else begin
        for (int d = 0; d < 6; d++)
          if ($countones(den_b) == 1 && den_b[d]) segs[7*d+:7] = seg_b;
      end
    end
  endtask

  function automatic logic [27:0] disp4(input int d3, input int d2, input int d1, input int d0);
    return {seg_lut[d3], seg_lut[d2], seg_lut[d1], seg_lut[d0]};
  endfunction

  task automatic pulse_load(input logic [15:0] v);
    load_val = v;
    load_en = 1;
    step();
    load_en = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    #1 rst = 1;
    #2;
    chk("rst_seg", seg_a, 7'b1111110);
    chk("rst_den", den_a, 4'b1110);
    chk("rst_run", run_a, 1'b0);
    chk("rst_exp", exp_a, 1'b0);
    #19 rst = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("scan%0d", k), den_a, scan_exp[k]);
    end
    chk("scan_seg", seg_a, 7'b1111110);
    pulse_start();
    repeat (488) step();
    chk("t1_run", run_a, 1'b1);
    chk("t1_exp", exp_a, 1'b0);
    stop = 1;
    step();
    stop = 0;
    chk("t1_stop", run_a, 1'b0);
    capture(0, 8, cap);
    chk("t1_0101", cap[27:0], disp4(0, 1, 0, 1));
    pulse_load(16'h5959);
    capture(0, 8, cap);
    chk("t2_load", cap[27:0], disp4(5, 9, 5, 9));
    pulse_start();
    repeat (8) step();
    chk("t2_run", run_a, 1'b1);
    chk("t2_exp", exp_a, 1'b0);
    stop = 1;
    step();
    stop = 0;
    capture(0, 8, cap);
    chk("t2_wrap", cap[27:0], disp4(0, 0, 0, 0));
    mode_down = 1;
    pulse_load(16'h0002);
    pulse_start();
    repeat (8) step();
    chk("t3_run8", run_a, 1'b1);
    chk("t3_exp8", exp_a, 1'b0);
    capture(0, 8, cap);
    chk("t3_0001", cap[27:0], disp4(0, 0, 0, 1));
    chk("t3_run16", run_a, 1'b0);
    chk("t3_exp16", exp_a, 1'b1);
    capture(0, 8, cap);
    chk("t3_0000", cap[27:0], disp4(0, 0, 0, 0));
    pulse_start();
    chk("t3_rs_run", run_a, 1'b0);
    chk("t3_rs_exp", exp_a, 1'b1);
    step();
    chk("t3_rs_exp2", exp_a, 1'b1);
    mode_down = 0;
    pulse_load(16'h0037);
    pulse_start();
    repeat (3) step();
    chk("t4_run", run_a, 1'b1);
    start = 1;
    stop = 1;
    clear = 1;
    step();
    start = 0;
    stop = 0;
    clear = 0;
    chk("t4_clr_run", run_a, 1'b0);
    chk("t4_clr_exp", exp_a, 1'b0);
    capture(0, 8, cap);
    chk("t4_clr_disp", cap[27:0], disp4(0, 0, 0, 0));
    start = 1;
    stop = 1;
    step();
    start = 0;
    stop = 0;
    chk("t4_ss_run", run_a, 1'b0);
    step();
    chk("t4_ss_run2", run_a, 1'b0);
    pulse_load(16'hF7A9);
    capture(0, 8, cap);
    chk("t5_clamp", cap[27:0], disp4(5, 7, 5, 9));
    pulse_start();
    repeat (3) step();
    chk("t5_run", run_a, 1'b1);
    #2 rst = 1;
    #1;
    chk("t5_arst_seg", seg_a, 7'b1111110);
    chk("t5_arst_den", den_a, 4'b1110);
    chk("t5_arst_run", run_a, 1'b0);
    chk("t5_arst_exp", exp_a, 1'b0);
    #2 rst = 0;
    capture(0, 8, cap);
    chk("t5_arst_disp", cap[27:0], disp4(0, 0, 0, 0));
    lv_b = 24'h000105;
    ld_b = 1;
    step();
    ld_b = 0;
    capture(1, 6, cap);
    chk("t6_blank", cap, {7'h7F, 7'h7F, 7'h7F, ~seg_lut[1], ~seg_lut[0], ~seg_lut[5]});
    chk("t6_onehot", $countones(den_b), 1);
    chk("t6_run", run_b, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
